// File: rtl/main_memory_controller.sv
// Line-granular main memory behind the LLC: one 128-bit request in, one response out.
// Response ACCESS_LATENCY+5 cycles after accept (1 cycle if illegal); holds response until resp_ready, accepts nothing meanwhile.
module main_memory_controller #(
   parameter int MAIN_MEMORY_BLOCK_SIZE    = 4,
   parameter int MAIN_MEMORY_NUM_BLOCKS    = 64,
   parameter int MAIN_MEMORY_ADDRESS_WIDTH = 32,
   parameter int MAIN_MEMORY_DATA_WIDTH    = 128,
   parameter int ACCESS_LATENCY            = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 req_valid,
   output logic                                 req_ready,
   input  logic                                 req_write,
   input  logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0] req_addr,
   input  logic [MAIN_MEMORY_DATA_WIDTH-1:0]    req_wdata,
   output logic                                 resp_valid,
   input  logic                                 resp_ready,
   output logic [MAIN_MEMORY_DATA_WIDTH-1:0]    resp_rdata,
   output logic                                 resp_error,
   output logic                                 busy
);
   localparam int BLK_W  = 8 * MAIN_MEMORY_BLOCK_SIZE;
   localparam int IDX_W  = $clog2(MAIN_MEMORY_NUM_BLOCKS);
   localparam int LINE_W = IDX_W - 2;
   localparam int OFF_W  = $clog2(MAIN_MEMORY_BLOCK_SIZE) + 2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_RESP} state_t;

   state_t                              state_q, state_d;
   logic [LINE_W-1:0]                   line_q, line_d;
   logic                                write_q, write_d;
   logic [MAIN_MEMORY_DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [MAIN_MEMORY_DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                                err_q, err_d;
   logic [7:0]                          lat_q, lat_d;
   logic [1:0]                          beat_q, beat_d;
   logic [BLK_W-1:0]                    mem_q [MAIN_MEMORY_NUM_BLOCKS];
   logic [BLK_W-1:0]                    mem_d [MAIN_MEMORY_NUM_BLOCKS];
   logic [IDX_W-1:0]                    idx;
   logic                                legal;

   assign req_ready  = rst_n && (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
   assign resp_error = (state_q == S_RESP) && err_q;
   assign busy       = (state_q != S_IDLE);

   assign idx   = {line_q, beat_q};
   assign legal = (req_addr[OFF_W-1:0] == '0) &&
                  (req_addr[MAIN_MEMORY_ADDRESS_WIDTH-1:OFF_W+LINE_W] == '0);

   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      write_d = write_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      lat_d   = lat_q;
      beat_d  = beat_q;
      mem_d   = mem_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               line_d  = req_addr[OFF_W+LINE_W-1:OFF_W];
               write_d = req_write;
               wdata_d = req_wdata;
               rdata_d = '0;
               lat_d   = '0;
               beat_d  = '0;
               err_d   = !legal;
               if (!legal)                   state_d = S_RESP;
               else if (ACCESS_LATENCY == 0) state_d = S_XFER;
               else                          state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (int'(lat_q) + 1 >= ACCESS_LATENCY) state_d = S_XFER;
            else                                   lat_d   = lat_q + 8'd1;
         end
         S_XFER: begin
            // One block per beat; the line's base block is always 4-aligned.
            if (write_q) mem_d[idx] = wdata_q[BLK_W*int'(beat_q) +: BLK_W];
            else         rdata_d[BLK_W*int'(beat_q) +: BLK_W] = mem_q[idx];
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3) state_d = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         line_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         lat_q   <= '0;
         beat_q  <= '0;
         for (int i = 0; i < MAIN_MEMORY_NUM_BLOCKS; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         lat_q   <= lat_d;
         beat_q  <= beat_d;
         mem_q   <= mem_d;
      end
   end
endmodule
